uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver. It captures each received byte together with its frame and parity error status into a first-word-fall-through FIFO. Host logic drains it through a valid/ready read port. It also reports fill level, a threshold interrupt, and a sticky overrun flag.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
THRESH, 8, fill level at or above which level_irq_o asserts; range 1..DEPTH

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
rx_data_i  in  8  byte from receiver, valid when rx_done_i=1
rx_done_i  in  1  single-cycle strobe: good byte available
frame_err_i  in  1  receiver frame-error flag; may be sticky (level)
parity_err_i  in  1  receiver parity-error flag; may be sticky (level)
rd_valid_o  out  1  head entry valid
rd_ready_i  in  1  consumer accepts head entry
rd_data_o  out  8  head entry data
rd_frame_err_o  out  1  head entry frame-error tag
rd_parity_err_o  out  1  head entry parity-error tag
flush_i  in  1  discard all entries
overrun_clr_i  in  1  clear overrun_o
count_o  out  $clog2(DEPTH)+1  current number of entries
empty_o  out  1  count_o==0
full_o  out  1  count_o==DEPTH
level_irq_o  out  1  count_o>=THRESH (registered)
overrun_o  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset values: all outputs 0, pointers 0, count 0, edge-detect registers 0, and empty_o=1. Storage contents are don't-care.
- Error edge detect: registered copies of frame_err_i and parity_err_i.
  - fe_rise = frame_err_i & ~fe_q; pe_rise = parity_err_i & ~pe_q.
- Push strobe: push = rx_done_i | fe_rise | pe_rise.
  - Entry = {pe_rise, fe_rise, rx_data_i}.
  - On error-only pushes the data field holds rx_data_i as sampled.
- Pop: pop = rd_valid_o & rd_ready_i.
- rd_valid_o = ~empty_o. Read data is first-word-fall-through: the head is on rd_* whenever rd_valid_o=1, with no read latency.
- Write-to-read latency: a push in cycle N gives rd_valid_o=1 with that entry in cycle N+1 (FIFO was empty).
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- count_o is updated as follows:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full FIFO, push with pop in the same cycle: the push is accepted and count stays at DEPTH. No overrun.
- Full FIFO, push without pop: the entry is dropped, pointers are unchanged, and overrun_o is set the next cycle.
- Empty FIFO, push: no pop is possible because rd_valid_o=0.
- overrun_o: set by a dropped push, cleared by overrun_clr_i. If both occur in the same cycle, set wins. Flush does not clear it.
- flush_i: next cycle pointers=0, count=0, rd_valid_o=0.
  - Any push or pop in the flush cycle is ignored. A push in that cycle is not counted as an overrun.
  - Edge-detect registers still update during flush.
- level_irq_o, full_o, empty_o and count_o are registered and consistent with each other in every cycle.
- Reset mid-operation: reset overrides flush, push and pop. State returns to the reset values the next cycle.

Decomposition:
- Package uart_pkg holds:
  - typedef rx_entry_t: packed struct {parity_err, frame_err, data[7:0]}
  - constant UART_DATA_W=8
- Sub-module uart_fifo_mem: DEPTH x rx_entry_t register array.
  - Write port: synchronous (we, waddr, wdata).
  - Read port: asynchronous (raddr -> rdata), which supports first-word fall-through.
- Pointer, count, status and edge-detect logic stay in uart_rx_fifo.

Test Plan:
- Reset, then rx_done_i pulses with 0x55 then 0xA3, rd_ready_i=1 → rd_valid_o rises one cycle after the first pulse; reads return 0x55 then 0xA3 with error tags 0; count_o goes 1, then back to 0.
- frame_err_i raised and held high for 20 cycles, with no rx_done_i → exactly one entry is pushed with rd_frame_err_o=1 and rd_parity_err_o=0; count_o=1.
- Fill 16 bytes 0x00..0x0F with rd_ready_i=0 → full_o=1, count_o=16, and level_irq_o is asserted from count 8 onward. Push 0xFF → overrun_o=1 and count stays 16. Drain all → data 0x00..0x0F in order; 0xFF is absent.
- FIFO full, push 0x77 in the same cycle as a pop → no overrun; count stays 16; 0x77 is read last.
- Assert overrun_clr_i together with a dropped push → overrun_o remains 1. Assert overrun_clr_i alone → 0 the next cycle.
- 5 entries held, then flush_i pulsed together with rx_done_i (0x42) → next cycle count_o=0, empty_o=1, rd_valid_o=0; 0x42 is never read.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive buffer: one FIFO entry is a byte plus its
// frame/parity error tags.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef struct packed {
      logic                   parity_err;
      logic                   frame_err;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

   localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: synchronous write, asynchronous
// read so the head entry can fall through with no latency.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [ENTRY_W-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [ENTRY_W-1:0]       rdata
);

   rx_entry_t mem_r [DEPTH];

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= rx_entry_t'(wdata);
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with error
// tagging, fill level, threshold interrupt and sticky overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int THRESH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               rx_data_i,
   input  logic                     rx_done_i,
   input  logic                     frame_err_i,
   input  logic                     parity_err_i,
   output logic                     rd_valid_o,
   input  logic                     rd_ready_i,
   output logic [7:0]               rd_data_o,
   output logic                     rd_frame_err_o,
   output logic                     rd_parity_err_o,
   input  logic                     flush_i,
   input  logic                     overrun_clr_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     level_irq_o,
   output logic                     overrun_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

   logic          fe_q_r;
   logic          pe_q_r;
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic          empty_r;
   logic          full_r;
   logic          irq_r;
   logic          overrun_r;

   logic          fe_rise_s;
   logic          pe_rise_s;
   logic          push_s;
   logic          pop_s;
   logic          wr_en_s;
   logic          rd_en_s;
   logic          drop_s;
   logic [CW-1:0] count_next_s;
   rx_entry_t     wr_entry_s;
   rx_entry_t     head_s;
   logic [ENTRY_W-1:0] rdata_s;

   // Push/pop qualification and next fill level.
   always_comb begin
      fe_rise_s    = frame_err_i & ~fe_q_r;
      pe_rise_s    = parity_err_i & ~pe_q_r;
      push_s       = rx_done_i | fe_rise_s | pe_rise_s;
      pop_s        = ~empty_r & rd_ready_i;
      wr_en_s      = 1'b0;
      rd_en_s      = 1'b0;
      drop_s       = 1'b0;
      count_next_s = count_r;
      wr_entry_s   = '{parity_err: pe_rise_s, frame_err: fe_rise_s, data: rx_data_i};

      if (flush_i) begin
         count_next_s = '0;
      end else begin
         // A full FIFO still takes a push when the head leaves in the same cycle.
         wr_en_s = push_s & (~full_r | pop_s);
         rd_en_s = pop_s;
         drop_s  = push_s & full_r & ~pop_s;
         case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
         endcase
      end
   end

   // Pointers, status flags and error edge-detect registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fe_q_r  <= 1'b0;
         pe_q_r  <= 1'b0;
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
         irq_r   <= 1'b0;
      end else begin
         fe_q_r <= frame_err_i;
         pe_q_r <= parity_err_i;
         if (flush_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
         end else begin
            if (wr_en_s) begin
               wptr_r <= wptr_r + AW'(1'b1);
            end
            if (rd_en_s) begin
               rptr_r <= rptr_r + AW'(1'b1);
            end
         end
         count_r <= count_next_s;
         empty_r <= (count_next_s == CW'(1'b0));
         full_r  <= (count_next_s == DEPTH_C);
         irq_r   <= (count_next_s >= THRESH_C);
      end
   end

   // Sticky overrun: a dropped push beats a simultaneous clear; flush leaves it alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (overrun_clr_i) begin
         overrun_r <= 1'b0;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk_i),
      .we    (wr_en_s),
      .waddr (wptr_r),
      .wdata (wr_entry_s),
      .raddr (rptr_r),
      .rdata (rdata_s)
   );

   // Head entry is shown only while valid so stale storage never leaks out.
   always_comb begin
      head_s = rx_entry_t'(rdata_s);
      if (empty_r) begin
         rd_data_o       = '0;
         rd_frame_err_o  = 1'b0;
         rd_parity_err_o = 1'b0;
      end else begin
         rd_data_o       = head_s.data;
         rd_frame_err_o  = head_s.frame_err;
         rd_parity_err_o = head_s.parity_err;
      end
   end

   assign rd_valid_o  = ~empty_r;
   assign count_o     = count_r;
   assign empty_o     = empty_r;
   assign full_o      = full_r;
   assign level_irq_o = irq_r;
   assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference model checked every cycle.
module tb_uart_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int THRESH = 8;

   logic       clk = 1'b0;
   logic       rst, rx_done, frame_err, parity_err, rd_ready, flush, ovr_clr;
   logic [7:0] rx_data;
   logic       rd_valid, rd_fe, rd_pe, empty, full, irq, overrun;
   logic [7:0] rd_data;
   logic [4:0] count;

   int vectors     = 0;
   int miscompares = 0;
   bit armed       = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rx_data_i       (rx_data),
      .rx_done_i       (rx_done),
      .frame_err_i     (frame_err),
      .parity_err_i    (parity_err),
      .rd_valid_o      (rd_valid),
      .rd_ready_i      (rd_ready),
      .rd_data_o       (rd_data),
      .rd_frame_err_o  (rd_fe),
      .rd_parity_err_o (rd_pe),
      .flush_i         (flush),
      .overrun_clr_i   (ovr_clr),
      .count_o         (count),
      .empty_o         (empty),
      .full_o          (full),
      .level_irq_o     (irq),
      .overrun_o       (overrun)
   );

   // Reference model: the FIFO is a queue of {parity, frame, data} entries.
   logic [9:0] q[$];
   logic m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0;
   logic m_fer, m_per, m_push, m_pop, m_full;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_fe  = 1'b0;
         m_pe  = 1'b0;
         m_ovr = 1'b0;
      end else begin
         m_fer  = frame_err & ~m_fe;
         m_per  = parity_err & ~m_pe;
         m_push = rx_done | m_fer | m_per;
         m_pop  = (q.size() != 0) && rd_ready;
         m_full = (q.size() == DEPTH);
         if (flush) begin
            q.delete();
            if (ovr_clr) m_ovr = 1'b0;
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push && m_full && !m_pop) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            if (m_push && (!m_full || m_pop)) q.push_back({m_per, m_fer, rx_data});
         end
         m_fe = frame_err;
         m_pe = parity_err;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (armed) begin
         chk("m_count", 32'(count), 32'(q.size()));
         chk("m_empty", 32'(empty), 32'(q.size() == 0));
         chk("m_full", 32'(full), 32'(q.size() == DEPTH));
         chk("m_irq", 32'(irq), 32'(q.size() >= THRESH));
         chk("m_valid", 32'(rd_valid), 32'(q.size() != 0));
         chk("m_overrun", 32'(overrun), 32'(m_ovr));
         if (q.size() != 0) chk("m_head", 32'({rd_pe, rd_fe, rd_data}), 32'(q[0]));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   logic [7:0] got [40];
   int         n;
   bit         fill_mode;

   initial begin
      rst = 1'b1; rx_done = 1'b0; frame_err = 1'b0; parity_err = 1'b0;
      rd_ready = 1'b0; flush = 1'b0; ovr_clr = 1'b0; rx_data = 8'h00;
      tick();
      armed = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      tick();

      // Two bytes through an always-ready consumer.
      rd_ready = 1'b1; rx_done = 1'b1; rx_data = 8'h55;
      chk("t1_valid_pre", 32'(rd_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(rd_valid), 32'd1);
      chk("t1_data0", 32'({rd_pe, rd_fe, rd_data}), 32'h055);
      chk("t1_count0", 32'(count), 32'd1);
      rx_data = 8'hA3;
      tick();
      chk("t1_data1", 32'({rd_pe, rd_fe, rd_data}), 32'h0A3);
      chk("t1_count1", 32'(count), 32'd1);
      rx_done = 1'b0;
      tick();
      chk("t1_count2", 32'(count), 32'd0);
      rd_ready = 1'b0;

      // Held frame error produces exactly one tagged entry.
      frame_err = 1'b1;
      repeat (20) tick();
      frame_err = 1'b0;
      tick();
      chk("t2_count", 32'(count), 32'd1);
      chk("t2_fe", 32'(rd_fe), 32'd1);
      chk("t2_pe", 32'(rd_pe), 32'd0);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk("t2_drained", 32'(count), 32'd0);

      // Fill to full, watching the threshold interrupt.
      for (int i = 0; i < DEPTH; i++) begin
         rx_done = 1'b1; rx_data = 8'(i);
         tick();
         chk("t3_count", 32'(count), 32'(i + 1));
         chk("t3_irq", 32'(irq), 32'((i + 1) >= THRESH));
      end
      chk("t3_full", 32'(full), 32'd1);
      rx_data = 8'hFF;
      tick();
      rx_done = 1'b0;
      chk("t3_overrun", 32'(overrun), 32'd1);
      chk("t3_count_ovr", 32'(count), 32'd16);

      // Clear coinciding with a dropped push loses; clear alone wins.
      rx_done = 1'b1; rx_data = 8'hEE; ovr_clr = 1'b1;
      tick();
      rx_done = 1'b0;
      chk("t5_set_wins", 32'(overrun), 32'd1);
      tick();
      ovr_clr = 1'b0;
      chk("t5_cleared", 32'(overrun), 32'd0);

      // Push and pop together on a full FIFO.
      chk("t4_head", 32'(rd_data), 32'h00);
      rx_done = 1'b1; rx_data = 8'h77; rd_ready = 1'b1;
      tick();
      rx_done = 1'b0; rd_ready = 1'b0;
      chk("t4_count", 32'(count), 32'd16);
      chk("t4_overrun", 32'(overrun), 32'd0);

      for (int k = 0; k < 40; k++) got[k] = 8'h00;
      n = 0;
      rd_ready = 1'b1;
      for (int k = 0; k < 40 && rd_valid; k++) begin
         got[n] = rd_data;
         n++;
         tick();
      end
      rd_ready = 1'b0;
      chk("t3_drain_len", 32'(n), 32'd16);
      for (int j = 0; j < 15; j++) chk("t3_drain_data", 32'(got[j]), 32'(j + 1));
      chk("t4_last", 32'(got[15]), 32'h77);

      // Flush with a coincident push.
      for (int i = 0; i < 5; i++) begin
         rx_done = 1'b1; rx_data = 8'(8'h30 + i);
         tick();
      end
      rx_done = 1'b0;
      chk("t6_count5", 32'(count), 32'd5);
      flush = 1'b1; rx_done = 1'b1; rx_data = 8'h42;
      tick();
      flush = 1'b0; rx_done = 1'b0;
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_valid", 32'(rd_valid), 32'd0);
      chk("t6_overrun", 32'(overrun), 32'd0);
      tick();
      chk("t6_still_empty", 32'(count), 32'd0);

      // Randomized traffic alternating fill-heavy and drain-heavy phases.
      fill_mode = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ((c % 64) == 0) fill_mode = ($urandom_range(0, 1) == 1);
         rx_done  = ($urandom_range(0, 99) < 45);
         rx_data  = 8'($urandom);
         rd_ready = fill_mode ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 4) frame_err = ~frame_err;
         if ($urandom_range(0, 99) < 4) parity_err = ~parity_err;
         flush    = ($urandom_range(0, 199) < 2);
         ovr_clr  = ($urandom_range(0, 99) < 5);
         rst      = ($urandom_range(0, 999) < 3);
         tick();
      end
      rst = 1'b0; rx_done = 1'b0; flush = 1'b0; ovr_clr = 1'b0; rd_ready = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
